// File: rtl/seq_detect_if.sv
// seq_detect_if: serial data, enable/clear and match/state/count outputs of the pattern detector
interface seq_detect_if #(
  parameter int LEN   = 4,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(LEN);
  logic             a;
  logic             c;
  logic             clr;
  logic             n;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] count;
  modport master (output a, c, clr, input n, state, count);
  modport slave  (input a, c, clr, output n, state, count);
endinterface

// File: rtl/seq_detect.sv
// seq_detect: KMP prefix-tracking serial pattern detector with registered match pulse and saturating count
module seq_detect #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input logic         clk,
  input logic         rst,
  seq_detect_if.slave bus
);
  localparam int SW = $clog2(LEN);
  // Longest suffix of (first k pattern bits, then b) that is a prefix, capped at LEN-1;
  // at k=LEN-1 with a matching b this yields the overlap restart state.
  function automatic int nxt(int k, logic b);
    int  m;
    logic ok;
    for (int l = (k + 1 < LEN - 1) ? k + 1 : LEN - 1; l > 0; l--) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        m = k + 1 - l + j;
        ok = ok & ((((m < k) ? PATTERN[LEN-1-m] : b)) == PATTERN[LEN-1-j]);
      end
      if (ok) return l;
    end
    return 0;
  endfunction
  logic [SW-1:0]    nt0 [LEN];
  logic [SW-1:0]    nt1 [LEN];
  logic [SW-1:0]    state_q, ns;
  logic [CNT_W-1:0] count_q;
  logic             n_q, hit;
  for (genvar k = 0; k < LEN; k++) begin : g_nt
    assign nt0[k] = SW'(nxt(k, 1'b0));
    assign nt1[k] = SW'(nxt(k, 1'b1));
  end
  always_comb begin
    hit = (state_q == SW'(LEN - 1)) && (bus.a == PATTERN[0]);
    ns  = (hit && OVERLAP == 0) ? '0 : (bus.a ? nt1[state_q] : nt0[state_q]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= '0;
      n_q     <= 1'b0;
      count_q <= '0;
    end else if (bus.clr) begin
      state_q <= '0;
      n_q     <= 1'b0;
      count_q <= '0;
    end else begin
      n_q <= bus.c && hit;
      if (bus.c) state_q <= ns;
      if (bus.c && hit && count_q != '1) count_q <= count_q + 1'b1;
    end
  assign bus.state = state_q;
  assign bus.n     = n_q;
  assign bus.count = count_q;
endmodule
